// File: rtl/player_hit_detect_if.sv
// Bundle of signals between the hit detector, the player bullet controller,
// the enemy formation controller and the enemy renderer.
// master: the surrounding game logic. slave: the hit detector.
interface player_hit_detect_if #(
    parameter int N_ENEMIES = 8
);
    logic                 frame_start;
    logic                 level_restart;
    logic                 bullet_active;
    logic [10:0]          bullet_X;
    logic [10:0]          bullet_Y;
    logic [10:0]          form_X;
    logic [10:0]          form_Y;
    logic [N_ENEMIES-1:0] enemy_alive;
    logic [4:0]           enemies_left;
    logic                 all_dead;
    logic                 hit_valid;
    logic [3:0]           hit_index;
    logic                 bullet_kill;
    logic                 busy;

    modport master (
        output frame_start, level_restart, bullet_active,
        output bullet_X, bullet_Y, form_X, form_Y,
        input  enemy_alive, enemies_left, all_dead,
        input  hit_valid, hit_index, bullet_kill, busy
    );

    modport slave (
        input  frame_start, level_restart, bullet_active,
        input  bullet_X, bullet_Y, form_X, form_Y,
        output enemy_alive, enemies_left, all_dead,
        output hit_valid, hit_index, bullet_kill, busy
    );
endinterface

// File: rtl/player_hit_detect.sv
// Player bullet vs. enemy formation hit detection. Once per frame the bullet
// and formation positions are snapshotted and enemies are tested one per
// clock; the first alive enemy struck is cleared and reported, and the
// bullet is retired.
module player_hit_detect #(
    parameter int N_ENEMIES         = 8,
    parameter int ENEMY_SPACING     = 96,
    parameter int HALF_ENEMY_WIDTH  = 24,
    parameter int HALF_ENEMY_HEIGHT = 16
) (
    input  logic                 pclk,
    input  logic                 rst,
    player_hit_detect_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t               state_q;
    logic [3:0]           idx_q;
    logic [10:0]          bullet_x_q;
    logic [10:0]          bullet_y_q;
    logic [10:0]          form_x_q;
    logic [10:0]          form_y_q;
    logic [N_ENEMIES-1:0] enemy_alive_q;
    logic [4:0]           enemies_left_q;
    logic                 all_dead_q;
    logic                 hit_valid_q;
    logic                 bullet_kill_q;
    logic [3:0]           hit_index_q;

    logic [N_ENEMIES-1:0] idx_onehot;
    logic [15:0]          cx_d;
    logic [15:0]          bx_d;
    logic [15:0]          by_d;
    logic [15:0]          fy_d;
    logic                 x_hit_d;
    logic                 y_hit_d;
    logic                 match_d;

    // One-hot select of the enemy under test; avoids a variable-width bit select.
    generate
        for (genvar gi = 0; gi < N_ENEMIES; gi++) begin : g_sel
            assign idx_onehot[gi] = (idx_q == 4'(gi));
        end
    endgenerate

    // Hit-box test of the current enemy against the snapshot. Everything is
    // widened to 16 bits and only additions are used, so nothing can wrap.
    always_comb begin
        cx_d    = 16'(form_x_q) + 16'(idx_q) * 16'(ENEMY_SPACING);
        bx_d    = 16'(bullet_x_q);
        by_d    = 16'(bullet_y_q);
        fy_d    = 16'(form_y_q);
        x_hit_d = (bx_d + 16'(HALF_ENEMY_WIDTH) >= cx_d) &&
                  (bx_d <= cx_d + 16'(HALF_ENEMY_WIDTH));
        y_hit_d = (by_d + 16'(HALF_ENEMY_HEIGHT) >= fy_d) &&
                  (by_d <= fy_d + 16'(HALF_ENEMY_HEIGHT));
        match_d = (|(enemy_alive_q & idx_onehot)) && x_hit_d && y_hit_d;
    end

    // Scan FSM with the alive mask, counters and registered pulses.
    // level_restart overrides any scan in progress.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= 4'd0;
            bullet_x_q     <= 11'd0;
            bullet_y_q     <= 11'd0;
            form_x_q       <= 11'd0;
            form_y_q       <= 11'd0;
            enemy_alive_q  <= '1;
            enemies_left_q <= 5'(N_ENEMIES);
            all_dead_q     <= 1'b0;
            hit_valid_q    <= 1'b0;
            bullet_kill_q  <= 1'b0;
            hit_index_q    <= 4'd0;
        end else if (bus.level_restart) begin
            state_q        <= IDLE;
            enemy_alive_q  <= '1;
            enemies_left_q <= 5'(N_ENEMIES);
            all_dead_q     <= 1'b0;
            hit_valid_q    <= 1'b0;
            bullet_kill_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.frame_start && bus.bullet_active && !all_dead_q) begin
                        bullet_x_q <= bus.bullet_X;
                        bullet_y_q <= bus.bullet_Y;
                        form_x_q   <= bus.form_X;
                        form_y_q   <= bus.form_Y;
                        idx_q      <= 4'd0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    if (match_d) begin
                        enemy_alive_q  <= enemy_alive_q & ~idx_onehot;
                        enemies_left_q <= enemies_left_q - 5'd1;
                        all_dead_q     <= (enemies_left_q == 5'd1);
                        hit_index_q    <= idx_q;
                        hit_valid_q    <= 1'b1;
                        bullet_kill_q  <= 1'b1;
                        state_q        <= REPORT;
                    end else if (idx_q == 4'(N_ENEMIES - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                REPORT: begin
                    hit_valid_q   <= 1'b0;
                    bullet_kill_q <= 1'b0;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.enemy_alive  = enemy_alive_q;
    assign bus.enemies_left = enemies_left_q;
    assign bus.all_dead     = all_dead_q;
    assign bus.hit_valid    = hit_valid_q;
    assign bus.bullet_kill  = bullet_kill_q;
    assign bus.hit_index    = hit_index_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_player_hit_detect.sv
// Directed bench for player_hit_detect: hits, hit-box boundaries, dead
// enemies, snapshot behaviour, all-dead gating and level restart.
module tb_player_hit_detect;
    localparam int N = 8;

    logic pclk = 1'b0;
    logic rst;
    always #5 pclk = ~pclk;

    player_hit_detect_if #(.N_ENEMIES(N)) bus ();

    player_hit_detect #(.N_ENEMIES(N)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [N-1:0] alive_m;
    int           left_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_alive"}, 32'(bus.enemy_alive), 32'(alive_m));
        check({tag, "_left"}, 32'(bus.enemies_left), 32'(left_m));
        check({tag, "_dead"}, 32'(bus.all_dead), 32'(left_m == 0));
    endtask

    task automatic restart(input string tag);
        bus.level_restart = 1'b1;
        tick();
        bus.level_restart = 1'b0;
        alive_m = '1;
        left_m  = N;
        check_state(tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        $display("restart %s alive=%b left=%0d", tag, bus.enemy_alive, bus.enemies_left);
    endtask

    // frame_start in cycle T (rel 0). mid_bx>=0 moves bullet_X in T+1,
    // restart_at>=0 raises level_restart in T+restart_at. exp_k is the enemy
    // expected to be hit (-1 for none); gated means no scan should start.
    task automatic do_scan(input string tag, input int bx, input int by, input int mid_bx,
                           input int restart_at, input int exp_k, input bit gated);
        int  end_c;
        bit  exp_b;
        bit  exp_hv;
        bit  killed;
        end_c = gated ? 0 : ((exp_k >= 0) ? exp_k + 2 : N);
        bus.bullet_X      = 11'(bx);
        bus.bullet_Y      = 11'(by);
        bus.frame_start   = 1'b1;
        bus.level_restart = (restart_at == 0);
        for (int rel = 1; rel <= N + 3; rel++) begin
            tick();
            bus.frame_start = 1'b0;
            if (rel == 1 && mid_bx >= 0) bus.bullet_X = 11'(mid_bx);
            bus.level_restart = (rel == restart_at);
            killed = (restart_at >= 0) && (rel > restart_at);
            exp_b  = (rel <= end_c) && !killed;
            exp_hv = (exp_k >= 0) && (rel == exp_k + 2) && !killed;
            check($sformatf("%s_busy_c%0d", tag, rel), 32'(bus.busy), 32'(exp_b));
            check($sformatf("%s_hv_c%0d", tag, rel), 32'(bus.hit_valid), 32'(exp_hv));
            check($sformatf("%s_kill_c%0d", tag, rel), 32'(bus.bullet_kill), 32'(exp_hv));
        end
        bus.level_restart = 1'b0;
        if (restart_at >= 0) begin
            alive_m = '1;
            left_m  = N;
        end else if (exp_k >= 0) begin
            alive_m[exp_k] = 1'b0;
            left_m--;
            check({tag, "_index"}, 32'(bus.hit_index), 32'(exp_k));
        end
        check_state(tag);
        $display("scan %s bullet=(%0d,%0d) exp_hit=%0d hit_index=%0d alive=%b left=%0d all_dead=%0b",
                 tag, bx, by, exp_k, bus.hit_index, bus.enemy_alive, bus.enemies_left, bus.all_dead);
    endtask

    initial begin
        rst               = 1'b1;
        bus.frame_start   = 1'b0;
        bus.level_restart = 1'b0;
        bus.bullet_active = 1'b1;
        bus.bullet_X      = 11'd0;
        bus.bullet_Y      = 11'd0;
        bus.form_X        = 11'd100;
        bus.form_Y        = 11'd200;
        alive_m           = '1;
        left_m            = N;
        tick();
        tick();
        rst = 1'b0;
        check_state("reset");
        check("reset_hv", 32'(bus.hit_valid), 32'd0);
        check("reset_kill", 32'(bus.bullet_kill), 32'd0);
        check("reset_index", 32'(bus.hit_index), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        $display("reset alive=%b left=%0d", bus.enemy_alive, bus.enemies_left);

        do_scan("hit2", 300, 210, -1, -1, 2, 1'b0);
        check("hit2_alive_const", 32'(bus.enemy_alive), 32'h0000_00FB);
        do_scan("dead2", 300, 210, -1, -1, -1, 1'b0);

        restart("r1");
        do_scan("xlo_ymax", 268, 216, -1, -1, 2, 1'b0);
        restart("r2");
        do_scan("xmiss", 267, 210, -1, -1, -1, 1'b0);
        do_scan("ymiss", 300, 217, -1, -1, -1, 1'b0);
        do_scan("midscan", 300, 210, 100, -1, 2, 1'b0);

        restart("r3");
        for (int i = 0; i < N; i++)
            do_scan($sformatf("kill%0d", i), 100 + 96 * i, 200, -1, -1, i, 1'b0);
        check("all_dead_final", 32'(bus.all_dead), 32'd1);
        do_scan("dead_ignore", 300, 210, -1, -1, -1, 1'b1);

        restart("r4");
        bus.bullet_active = 1'b0;
        do_scan("inactive", 300, 210, -1, -1, -1, 1'b1);
        bus.bullet_active = 1'b1;
        do_scan("rst_mid", 580, 200, -1, 2, -1, 1'b0);
        do_scan("rst_same", 300, 210, -1, 0, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
